// File: rtl/fpu_pkg.sv
// Shared FPU front-end definitions: pre-normalization FSM states and requester ids.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    SHF  = 2'd2,
    RESP = 2'd3
  } norm_state_t;

  localparam logic REQ_DIVIDEND = 1'b0;
  localparam logic REQ_DIVISOR  = 1'b1;

endpackage

// File: rtl/lz_counting.sv
// Combinational leading-zero counter; an all-zero input reports a count of 0.
module lz_counting #(
  parameter int WIDTH = 32,
  parameter int LZW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [LZW-1:0]   cnt_o,
  output logic             all_bits_zero_o
);

  logic found;

  always_comb begin
    cnt_o = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in_i[i]) begin
        cnt_o = LZW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
    all_bits_zero_o = ~found;
  end

endmodule

// File: rtl/fdiv_norm_arbiter.sv
// Round-robin sequencer sharing one LZC between the FDiv dividend and divisor
// pre-normalization requesters; one operation in flight, 3-cycle accept-to-valid.
module fdiv_norm_arbiter
  import fpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LZW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  input  logic [WIDTH-1:0] req_op0_i,
  input  logic [WIDTH-1:0] req_op1_i,
  output logic [1:0]       req_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_id_o,
  output logic [WIDTH-1:0] out_mant_o,
  output logic [LZW-1:0]   out_lzc_o,
  output logic             out_zero_o
);

  norm_state_t      state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] mant_q, mant_d;
  logic [LZW-1:0]   lzc_q, lzc_d;
  logic             zero_q, zero_d;

  logic [LZW-1:0]   lzc_w;
  logic             zero_w;
  logic [1:0]       grant;
  logic             gid;
  logic             oth;

  lz_counting #(.WIDTH(WIDTH), .LZW(LZW)) u_lzc (
    .in_i            (op_q),
    .cnt_o           (lzc_w),
    .all_bits_zero_o (zero_w)
  );

  // Pointer holder has priority; otherwise the other requester if it is asking.
  always_comb begin
    grant = 2'b00;
    gid   = ptr_q;
    oth   = ~ptr_q;
    if (state_q == IDLE && !rst_i) begin
      if (req_valid_i[ptr_q]) begin
        grant[ptr_q] = 1'b1;
        gid          = ptr_q;
      end else if (req_valid_i[oth]) begin
        grant[oth] = 1'b1;
        gid        = oth;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    mant_d  = mant_q;
    lzc_d   = lzc_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          id_d    = gid;
          op_d    = (gid == REQ_DIVISOR) ? req_op1_i : req_op0_i;
          ptr_d   = ~gid;
          state_d = CNT;
        end
      end
      CNT: begin
        lzc_d   = lzc_w;
        zero_d  = zero_w;
        state_d = SHF;
      end
      SHF: begin
        mant_d  = op_q << lzc_q;
        state_d = RESP;
      end
      RESP: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= '0;
      mant_q  <= '0;
      lzc_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      mant_q  <= mant_d;
      lzc_q   <= lzc_d;
      zero_q  <= zero_d;
    end
  end

  assign req_ready_o = grant;
  assign out_valid_o = (state_q == RESP);
  assign out_id_o    = id_q;
  assign out_mant_o  = mant_q;
  assign out_lzc_o   = lzc_q;
  assign out_zero_o  = zero_q;

endmodule

// File: tb/tb_fdiv_norm_arbiter.sv
// Self-checking bench: spec vector table, backpressure and reset sequences, randomized ops.
module tb_fdiv_norm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_op0, req_op1;
  logic [1:0]  req_ready;
  logic        out_valid, out_ready, out_id, out_zero;
  logic [31:0] out_mant;
  logic [4:0]  out_lzc;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  fdiv_norm_arbiter #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_op0_i(req_op0),
    .req_op1_i(req_op1), .req_ready_o(req_ready), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_id_o(out_id), .out_mant_o(out_mant),
    .out_lzc_o(out_lzc), .out_zero_o(out_zero)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] op0, op1;
    logic        hold;
    logic        exp_id;
    logic [4:0]  exp_lzc;
    logic [31:0] exp_mant;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count zeros from the MSB by plain search.
  function automatic int ref_lzc(input logic [31:0] op);
    int n = 0;
    while (n < 32 && op[31-n] == 1'b0) n++;
    return (n == 32) ? 0 : n;
  endfunction

  task automatic run_op(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                        input logic hold, input logic e_id, input logic [4:0] e_lzc,
                        input logic [31:0] e_mant, input logic e_zero, input string tag);
    int k = 0;
    int lat = 0;
    @(negedge clk);
    req_valid = v; req_op0 = a; req_op1 = b; out_ready = 1'b1;
    #1;
    while (req_ready == 2'b00 && k < 10) begin
      @(negedge clk); #1; k++;
    end
    if (k == 10) begin
      chk({tag, "_grant_timeout"}, 32'(k), 32'd0);
      return;
    end
    chk({tag, "_grant_wait"}, 32'(k), 32'd0);
    chk({tag, "_grant"}, 32'(req_ready), 32'(2'b01 << e_id));
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      if (!hold) req_valid = 2'b00;
      #1; lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_id"}, 32'(out_id), 32'(e_id));
    chk({tag, "_lzc"}, 32'(out_lzc), 32'(e_lzc));
    chk({tag, "_mant"}, out_mant, e_mant);
    chk({tag, "_zero"}, 32'(out_zero), 32'(e_zero));
    chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_op0 = '0; req_op1 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_id",    32'(out_id),    32'd0);
    chk("rst_mant",  out_mant,       32'd0);
    chk("rst_lzc",   32'(out_lzc),   32'd0);
    chk("rst_zero",  32'(out_zero),  32'd0);
    rst = 1'b0;

    vecs[0] = '{2'b01, 32'h0000_1234, 32'h0,          1'b0, 1'b0, 5'd19, 32'h91A0_0000, 1'b0};
    vecs[1] = '{2'b10, 32'h0,          32'h0,          1'b0, 1'b1, 5'd0,  32'h0,          1'b1};
    vecs[2] = '{2'b11, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 5'd0,  32'h8000_0000, 1'b0};
    vecs[3] = '{2'b11, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 5'd31, 32'h8000_0000, 1'b0};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 5'd0,  32'h8000_0000, 1'b0};
    vecs[5] = '{2'b11, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 5'd31, 32'h8000_0000, 1'b0};
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].valid, vecs[i].op0, vecs[i].op1, vecs[i].hold, vecs[i].exp_id,
             vecs[i].exp_lzc, vecs[i].exp_mant, vecs[i].exp_zero, $sformatf("vec%0d", i));

    // Backpressure: hold RESP for 5 cycles with both requesters asking.
    @(negedge clk);
    req_valid = 2'b01; req_op0 = 32'h00F0_0000; out_ready = 1'b0;
    #1; chk("bp_grant", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    req_valid = 2'b11; req_op1 = 32'h0000_0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_mant",  out_mant,       32'hF000_0000);
      chk("bp_lzc",   32'(out_lzc),   32'd8);
      chk("bp_id",    32'(out_id),    32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1; chk("bp_hs_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'd2);
    chk("bp_next_novalid", 32'(out_valid), 32'd0);
    @(negedge clk);
    req_valid = 2'b00; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset in SHF drops the operand and clears the pointer.
    req_valid = 2'b01; req_op0 = 32'h0000_00FF;
    #1; chk("mr_grant", 32'(req_ready), 32'd1);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    chk("mr_mant",  out_mant,       32'd0);
    chk("mr_lzc",   32'(out_lzc),   32'd0);
    chk("mr_zero",  32'(out_zero),  32'd0);
    chk("mr_id",    32'(out_id),    32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("mr_no_resp", 32'(out_valid), 32'd0);
    end
    run_op(2'b11, 32'h0000_0003, 32'h4000_0000, 1'b0, 1'b0, 5'd30, 32'hC000_0000, 1'b0, "mr_post");
    m_ptr = 1;

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  v;
      logic [31:0] a, b, op;
      int          id, n;
      v = 2'($urandom_range(1, 3));
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 7) == 0) b = '0;
      id = v[m_ptr] ? m_ptr : 1 - m_ptr;
      op = (id == 1) ? b : a;
      n  = ref_lzc(op);
      run_op(v, a, b, 1'b0, id[0], 5'(n), op << n, op == 0, $sformatf("rnd%0d", i));
      m_ptr = 1 - id;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
